// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access unit: sizes, aligns and issues loads/stores on a req/gnt + rvalid bus.
// Latency: store 3 cycles minimum (IDLE, REQ+gnt, DONE); load 4 cycles minimum (rvalid one cycle after gnt).
// Backpressure: stall_mem holds the pipeline from acceptance until the bus completes; DONE releases it for one cycle.
module mem_access_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_m,
  input  logic              mem_write_m,
  input  logic [1:0]        mem_size_m,
  input  logic              mem_unsigned_m,
  input  logic [ADDR_W-1:0] alu_out_m,
  input  logic [DATA_W-1:0] write_data_m,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] read_data_m,
  output logic              stall_mem,
  output logic              misalign_m
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  // Latched copy of the access; the pipeline is frozen, so these govern the whole transaction.
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [3:0]        r_be;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_lane;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [DATA_W-1:0] r_rdata;

  logic              w_access;
  logic              w_store;
  logic              w_misalign;
  logic              w_start;
  logic [1:0]        w_lane;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_shift;
  logic [DATA_W-1:0] w_load_fmt;

  // Reset gates the access so stall/misalign read zero while rst is held.
  assign w_access = (mem_read_m | mem_write_m) & ~rst;
  // A simultaneous read+write is treated as a store.
  assign w_store  = mem_write_m;
  assign w_lane   = alu_out_m[1:0];

  // Half needs an even address, word needs a 4-byte aligned address.
  always_comb begin
    w_misalign = 1'b0;
    case (mem_size_m)
      2'b00:   w_misalign = 1'b0;
      2'b01:   w_misalign = w_lane[0];
      default: w_misalign = (w_lane != 2'b00);
    endcase
  end

  // Byte enables and lane-replicated store data; loads carry no byte enables.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = write_data_m;
    case (mem_size_m)
      2'b00: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {(DATA_W/8){write_data_m[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << w_lane;
        w_wdata = {(DATA_W/16){write_data_m[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = write_data_m;
      end
    endcase
    if (!w_store) begin
      w_be = 4'b0000;
    end
  end

  // Move the addressed byte/half down to bit 0, then extend per the latched size/signedness.
  assign w_shift = dmem_rdata >> {r_lane, 3'b000};

  // Format the returned word into the load result.
  always_comb begin
    w_load_fmt = dmem_rdata;
    case (r_size)
      2'b00:   w_load_fmt = r_uns ? {{(DATA_W-8){1'b0}}, w_shift[7:0]}
                                  : {{(DATA_W-8){w_shift[7]}}, w_shift[7:0]};
      2'b01:   w_load_fmt = r_uns ? {{(DATA_W-16){1'b0}}, w_shift[15:0]}
                                  : {{(DATA_W-16){w_shift[15]}}, w_shift[15:0]};
      default: w_load_fmt = dmem_rdata;
    endcase
  end

  // State register; reset abandons any in-flight request immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and stall/misalign decode.
  always_comb begin
    w_state_nxt = r_state;
    stall_mem   = 1'b0;
    misalign_m  = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          if (w_misalign) begin
            misalign_m = 1'b1;
          end else begin
            stall_mem   = 1'b1;
            w_start     = 1'b1;
            w_state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        stall_mem = 1'b1;
        if (dmem_gnt) begin
          w_state_nxt = r_we ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        stall_mem = 1'b1;
        if (dmem_rvalid) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Capture the access fields when an aligned access is accepted in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_be    <= 4'b0000;
      r_wdata <= '0;
      r_lane  <= 2'b00;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
    end else if (w_start) begin
      r_addr  <= {alu_out_m[ADDR_W-1:2], 2'b00};
      r_we    <= w_store;
      r_be    <= w_be;
      r_wdata <= w_wdata;
      r_lane  <= w_lane;
      r_size  <= mem_size_m;
      r_uns   <= mem_unsigned_m;
    end
  end

  // Load result register; only rvalid while waiting updates it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (r_state == S_WAIT && dmem_rvalid) begin
      r_rdata <= w_load_fmt;
    end
  end

  assign dmem_req    = (r_state == S_REQ);
  assign dmem_we     = dmem_req & r_we;
  assign dmem_be     = dmem_req ? r_be : 4'b0000;
  assign dmem_addr   = r_addr;
  assign dmem_wdata  = r_wdata;
  assign read_data_m = r_rdata;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage data-memory access unit of the 5-stage MIPS pipeline. Sits between EX/MEM and MEM/WB pipeline registers; consumes address/store data/control of the instruction in MEM and produces the formatted load value (read_data_m) latched by MEM/WB.
- Talks to data memory over a req/gnt + rvalid bus, handles byte/half/word sizing, sign/zero extension, misalignment detection, and raises stall_mem to the hazard unit while a bus transaction is outstanding.

Parameters:
DATA_W, 32, data bus and register width
ADDR_W, 32, byte address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
mem_read_m  in  1  load in MEM
mem_write_m  in  1  store in MEM
mem_size_m  in  2  00 byte, 01 half, 10/11 word
mem_unsigned_m  in  1  1 = zero-extend load, 0 = sign-extend
alu_out_m  in  ADDR_W  byte address
write_data_m  in  DATA_W  store data (low bits significant)
dmem_req  out  1  bus request
dmem_we  out  1  1 = write
dmem_addr  out  ADDR_W  word-aligned address (bits[1:0]=00)
dmem_wdata  out  DATA_W  lane-replicated store data
dmem_be  out  4  byte enables
dmem_gnt  in  1  request accepted this cycle
dmem_rvalid  in  1  read data valid
dmem_rdata  in  DATA_W  read word
read_data_m  out  DATA_W  formatted load result, registered
stall_mem  out  1  freeze IF..MEM and hold MEM/WB
misalign_m  out  1  misaligned access, combinational

Behaviour:
- Reset (async): state IDLE; dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, read_data_m = 0; stall_mem, misalign_m = 0.
- Access = mem_read_m | mem_write_m; both set -> treated as store.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=00. In IDLE: misalign_m=1, stall_mem=0, no bus activity, state stays IDLE, read_data_m unchanged.
- FSM states IDLE, REQ, WAIT, DONE:
  - IDLE: aligned access -> register addr (word-aligned), we, be, wdata, lane and size/unsigned; stall_mem=1 combinationally; -> REQ. No access -> stay, stall_mem=0.
  - REQ: dmem_req=1 with registered fields, held stable until dmem_gnt. gnt & store -> DONE; gnt & load -> WAIT. stall_mem=1. rvalid in REQ ignored.
  - WAIT: dmem_req=0; on dmem_rvalid capture formatted data into read_data_m, -> DONE. stall_mem=1.
  - DONE: stall_mem=0 for exactly one cycle (pipeline advances, MEM/WB captures read_data_m); no new request started; -> IDLE.
- Minimum latency: store 3 cycles (IDLE, REQ w/ gnt, DONE); load 4 cycles (rvalid earliest one cycle after gnt).
- Byte enables (little-endian, lane = addr[1:0]): byte 0001<<lane; half 0011<<lane; word 1111. wdata: byte replicated x4, half replicated x2, word as-is. dmem_be=0 and dmem_we=0 when no request.
- Load format: select byte/half at lane from dmem_rdata; extend to DATA_W per mem_unsigned latched at IDLE.
- Reset mid-transaction: immediate return to IDLE, dmem_req drops asynchronously; memory side must tolerate the abandoned request.
- Input changes while not IDLE are ignored (pipeline is stalled; latched copies govern).

Test Plan:
- lb, addr 0x1003, rdata 0x80_12_34_56, signed -> req with addr 0x1000, be 0000 (read), read_data_m=0xFFFFFF80, stall_mem high 3 cycles then low 1 (gnt and rvalid immediate).
- lhu, addr 0x2002, rdata 0xBEEF_1234 -> read_data_m=0x0000BEEF; lh same -> 0xFFFFBEEF.
- sb, addr 0x3001, write_data 0x000000AB -> dmem_we=1, be 0010, wdata 0xABABABAB, addr 0x3000; store finishes in 3 cycles.
- sw with dmem_gnt delayed 4 cycles -> req/addr/wdata/be stable throughout, stall_mem high 5 cycles, DONE one cycle.
- lw at 0x4002 -> misalign_m=1, dmem_req never asserted, stall_mem=0, read_data_m unchanged.
- lw granted, rst pulsed in WAIT -> same-cycle return to IDLE, read_data_m=0, stall_mem=0; late rvalid afterward ignored.
